regif_mst_responder: RTL

REGIF_MST_RESPONDER -- requirements
Module: regif_mst_responder

---
 rtl/regif_pkg.sv | 36 +++
 rtl/regif_reg_bank.sv | 72 +++++++
 rtl/regif_mst_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/regif_pkg.sv
// ============================================================================
// Module : regif_pkg
// Shared types and constants for the register-interface master responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_DATA  = 2'd2,
    ST_CMPLT = 2'd3
  } state_e;

  localparam int NUM_RW_REGS = 12;
  localparam int NUM_RO_REGS = 4;
  localparam int REG_IDX_W   = 4;

  localparam logic [31:0]          MISS_RDATA   = 32'h0000_0000;
  localparam logic [REG_IDX_W-1:0] FIRST_RO_IDX = REG_IDX_W'(NUM_RW_REGS);

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regif_reg_bank.sv
// ============================================================================
// Module : regif_reg_bank
// RW register array with byte-enable merge, write strobes and read mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regif_reg_bank
  import regif_pkg::*;
#(
  parameter logic [31:0] RW_RST_VAL = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [REG_IDX_W-1:0]       idx_i,
  input  logic [3:0]                 be_i,
  input  logic [31:0]                wdata_i,
  input  logic [32*NUM_RO_REGS-1:0]  status_i,
  output logic [32*NUM_RW_REGS-1:0]  reg_o,
  output logic [NUM_RW_REGS-1:0]     wr_stb_o,
  output logic [31:0]                rdata_o
);

  logic [31:0]            regs_q [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] wr_sel;
  logic [NUM_RW_REGS-1:0] wr_stb_q;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      wr_sel[i] = we_i && (idx_i == REG_IDX_W'(i));
    end
  end

  generate
    for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_rw
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          regs_q[i] <= RW_RST_VAL;
        end else if (wr_sel[i]) begin
          regs_q[i] <= be_merge(regs_q[i], wdata_i, be_i);
        end
      end
      assign reg_o[32*i +: 32] = regs_q[i];
    end
  endgenerate

  // Strobe is registered alongside the data so both appear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_stb_q <= '0;
    end else begin
      wr_stb_q <= wr_sel;
    end
  end

  assign wr_stb_o = wr_stb_q;

  always_comb begin
    rdata_o = MISS_RDATA;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (idx_i == REG_IDX_W'(i)) rdata_o = regs_q[i];
    end
    for (int k = 0; k < NUM_RO_REGS; k++) begin
      if (idx_i == REG_IDX_W'(NUM_RW_REGS + k)) rdata_o = status_i[32*k +: 32];
    end
  end

endmodule

`default_nettype wire

// File: rtl/regif_mst_responder.sv
// ============================================================================
// Module : regif_mst_responder
// Single-beat master-bus responder fronting a 12 RW + 4 RO register window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regif_mst_responder
  import regif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] RW_RST_VAL = 32'h0000_0000
) (
  input  logic          reg_int_clk,
  input  logic          reg_int_rst,
  input  logic          IP2Bus_MstRd_Req,
  input  logic          IP2Bus_MstWr_Req,
  input  logic [31:0]   IP2Bus_Mst_Addr,
  input  logic [3:0]    IP2Bus_Mst_BE,
  input  logic          IP2Bus_Mst_Lock,
  input  logic          IP2Bus_Mst_Reset,
  input  logic [31:0]   IP2Bus_MstWr_d,
  output logic          Bus2IP_Mst_CmdAck,
  output logic          Bus2IP_Mst_Cmplt,
  output logic          Bus2IP_Mst_Error,
  output logic          Bus2IP_Mst_Rearbitrate,
  output logic          Bus2IP_Mst_Timeout,
  output logic          Bus2IP_MstRd_src_rdy_n,
  output logic          Bus2IP_MstWr_dst_rdy_n,
  output logic [31:0]   Bus2IP_MstRd_d,
  input  logic [127:0]  status_in,
  output logic [383:0]  reg_out,
  output logic [11:0]   wr_stb
);

  state_e               state_q, state_d;
  logic                 is_wr_q, is_wr_d;
  logic                 hit_q, hit_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic [3:0]           be_q, be_d;
  logic                 cmdack_q, cmdack_d;
  logic                 cmplt_q, cmplt_d;
  logic                 error_q, error_d;
  logic                 src_rdy_n_q, src_rdy_n_d;
  logic                 dst_rdy_n_q, dst_rdy_n_d;
  logic [31:0]          rd_d_q, rd_d_d;
  logic                 bank_we;
  logic [31:0]          bank_rdata;
  logic                 unused_ok;

  assign unused_ok = ^{IP2Bus_Mst_Lock, IP2Bus_Mst_Addr[1:0]};

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    hit_d       = hit_q;
    idx_d       = idx_q;
    be_d        = be_q;
    cmdack_d    = 1'b0;
    cmplt_d     = 1'b0;
    error_d     = 1'b0;
    src_rdy_n_d = 1'b1;
    dst_rdy_n_d = 1'b1;
    rd_d_d      = MISS_RDATA;
    bank_we     = 1'b0;
    // Master reset overrides everything, including a pending write in DATA.
    if (IP2Bus_Mst_Reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IP2Bus_MstWr_Req || IP2Bus_MstRd_Req) begin
            is_wr_d  = IP2Bus_MstWr_Req;
            hit_d    = (IP2Bus_Mst_Addr[31:6] == BASE_ADDR[31:6]);
            idx_d    = IP2Bus_Mst_Addr[5:2];
            be_d     = IP2Bus_Mst_BE;
            cmdack_d = 1'b1;
            state_d  = ST_ACK;
          end
        end
        ST_ACK: begin
          state_d = ST_DATA;
          if (is_wr_q) begin
            dst_rdy_n_d = 1'b0;
          end else begin
            src_rdy_n_d = 1'b0;
            rd_d_d      = hit_q ? bank_rdata : MISS_RDATA;
          end
        end
        ST_DATA: begin
          state_d = ST_CMPLT;
          cmplt_d = 1'b1;
          error_d = !hit_q || (is_wr_q && (idx_q >= FIRST_RO_IDX));
          bank_we = is_wr_q && hit_q && (idx_q < FIRST_RO_IDX);
        end
        ST_CMPLT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge reg_int_clk or posedge reg_int_rst) begin
    if (reg_int_rst) begin
      state_q     <= ST_IDLE;
      is_wr_q     <= 1'b0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      be_q        <= '0;
      cmdack_q    <= 1'b0;
      cmplt_q     <= 1'b0;
      error_q     <= 1'b0;
      src_rdy_n_q <= 1'b1;
      dst_rdy_n_q <= 1'b1;
      rd_d_q      <= MISS_RDATA;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
      cmdack_q    <= cmdack_d;
      cmplt_q     <= cmplt_d;
      error_q     <= error_d;
      src_rdy_n_q <= src_rdy_n_d;
      dst_rdy_n_q <= dst_rdy_n_d;
      rd_d_q      <= rd_d_d;
    end
  end

  regif_reg_bank #(
    .RW_RST_VAL (RW_RST_VAL)
  ) u_bank (
    .clk_i    (reg_int_clk),
    .rst_i    (reg_int_rst),
    .we_i     (bank_we),
    .idx_i    (idx_q),
    .be_i     (be_q),
    .wdata_i  (IP2Bus_MstWr_d),
    .status_i (status_in),
    .reg_o    (reg_out),
    .wr_stb_o (wr_stb),
    .rdata_o  (bank_rdata)
  );

  assign Bus2IP_Mst_CmdAck      = cmdack_q;
  assign Bus2IP_Mst_Cmplt       = cmplt_q;
  assign Bus2IP_Mst_Error       = error_q;
  assign Bus2IP_Mst_Rearbitrate = 1'b0;
  assign Bus2IP_Mst_Timeout     = 1'b0;
  assign Bus2IP_MstRd_src_rdy_n = src_rdy_n_q;
  assign Bus2IP_MstWr_dst_rdy_n = dst_rdy_n_q;
  assign Bus2IP_MstRd_d         = rd_d_q;

endmodule

`default_nettype wire
